// File: rtl/csr_int_scheduler.sv
// csr_int_scheduler: interrupt scheduler in front of the MA-stage CSR executor.
// Latches interrupt sources into a pending vector (MIP view), arbitrates the
// enabled pending bits by fixed priority (14, 11, 3, 7, 12, 13) and offers one
// frozen request (cause + trap address) to the pipeline until it is acked or
// becomes invalid. After a trap return a hold-off window blocks new requests.
//
// Optional feature macro: CSR_INT_VECTORED_EN
//   defined   : mtvec mode 2'b01 gives trap = base + 4*cause
//   undefined : trap is always the base address
//
// Ports:
//   s_clk_i, s_resetn_i        clock, async active-low reset
//   s_stall_i, s_flush_i       MA stage stalled / flushed
//   s_meip_i/s_mtip_i/s_msip_i level interrupt sources
//   s_uce_i/s_lcer_i/s_fcer_i  error pulses (sticky pending bits 14/12/13)
//   s_mie_i, s_gie_i           enable mask and global enable
//   s_mtvec_i                  trap vector CSR
//   s_mip_we_i, s_mip_wdata_i  software MIP write (clears sticky bits)
//   s_int_ack_i, s_mret_i      pipeline took the interrupt / trap return
//   s_int_req_o, s_int_cause_o, s_int_trap_o  frozen request
//   s_mip_o                    pending vector
module csr_int_scheduler #(
  parameter int unsigned HOLDOFF_CYC = 2,
  parameter int unsigned CW          = 4
) (
  input  logic        s_clk_i,
  input  logic        s_resetn_i,
  input  logic        s_stall_i,
  input  logic        s_flush_i,
  input  logic        s_meip_i,
  input  logic        s_mtip_i,
  input  logic        s_msip_i,
  input  logic        s_uce_i,
  input  logic        s_lcer_i,
  input  logic        s_fcer_i,
  input  logic [14:0] s_mie_i,
  input  logic        s_gie_i,
  input  logic [31:0] s_mtvec_i,
  input  logic        s_mip_we_i,
  input  logic [14:0] s_mip_wdata_i,
  input  logic        s_int_ack_i,
  input  logic        s_mret_i,
  output logic        s_int_req_o,
  output logic [4:0]  s_int_cause_o,
  output logic [31:0] s_int_trap_o,
  output logic [14:0] s_mip_o
);

  typedef enum logic [1:0] {IDLE, REQ, CLR} state_e;

  state_e          state_q, state_d;
  logic [14:0]     mip_q, mip_d;
  logic [4:0]      cause_q, cause_d;
  logic [31:0]     trap_q, trap_d;
  logic [CW-1:0]   hold_q, hold_d;

  logic [14:0]     elig;
  logic            can_raise;
  logic [4:0]      sel_cause;
  logic [31:0]     trap_base, trap_next;
  logic [2:0]      sticky_set;

  // Flush does not affect the request; wdata bits below 12 are ignored.
  logic unused_ok;
  assign unused_ok = ^{s_flush_i, s_mtvec_i[1:0], s_mip_wdata_i[11:0]};

  assign elig       = mip_q & s_mie_i;
  assign can_raise  = (|elig) && s_gie_i && (hold_q == '0);
  assign sticky_set = {s_uce_i, s_fcer_i, s_lcer_i};   // bits 14,13,12

  always_comb begin
    sel_cause = 5'd0;
    if      (elig[14]) sel_cause = 5'd14;
    else if (elig[11]) sel_cause = 5'd11;
    else if (elig[3])  sel_cause = 5'd3;
    else if (elig[7])  sel_cause = 5'd7;
    else if (elig[12]) sel_cause = 5'd12;
    else if (elig[13]) sel_cause = 5'd13;
  end

  assign trap_base = {s_mtvec_i[31:2], 2'b00};
`ifdef CSR_INT_VECTORED_EN
  assign trap_next = (s_mtvec_i[1:0] == 2'b01) ?
                     trap_base + {25'd0, sel_cause, 2'b00} : trap_base;
`else
  assign trap_next = trap_base;
`endif

  // Pending vector: level bits are plain registered copies; sticky bits are
  // set by pulses, cleared when taken (CLR) or by a MIP write of 0. Set wins.
  always_comb begin
    mip_d     = '0;
    mip_d[3]  = s_msip_i;
    mip_d[7]  = s_mtip_i;
    mip_d[11] = s_meip_i;
    for (int b = 12; b < 15; b++) begin
      logic clr;
      clr = (s_mip_we_i && !s_mip_wdata_i[b]) ||
            (state_q == CLR && cause_q == 5'(b));
      mip_d[b] = sticky_set[b-12] || (mip_q[b] && !clr);
    end
  end

  always_comb begin
    if (s_mret_i)                       hold_d = CW'(HOLDOFF_CYC);
    else if (hold_q != '0 && !s_stall_i) hold_d = hold_q - 1'b1;
    else                                hold_d = hold_q;
  end

  // Next-state logic; cause/trap only change on IDLE->REQ so they stay frozen.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    trap_d  = trap_q;
    unique case (state_q)
      IDLE: if (can_raise && !s_stall_i) begin
        state_d = REQ;
        cause_d = sel_cause;
        trap_d  = trap_next;
      end
      REQ: begin
        if (s_int_ack_i)                                  state_d = CLR;
        else if (!elig[cause_q] || !s_gie_i || s_mret_i) state_d = IDLE;
      end
      CLR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      state_q <= IDLE;
      mip_q   <= '0;
      cause_q <= '0;
      trap_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      mip_q   <= mip_d;
      cause_q <= cause_d;
      trap_q  <= trap_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    s_int_req_o   = (state_q == REQ);
    s_int_cause_o = cause_q;
    s_int_trap_o  = trap_q;
    s_mip_o       = mip_q;
  end

endmodule

// File: tb/tb_csr_int_scheduler.sv
module tb_csr_int_scheduler;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        stall = 0, flush = 0, meip = 0, mtip = 0, msip = 0;
  logic        uce = 0, lcer = 0, fcer = 0, gie = 0, mip_we = 0, ack = 0, mret = 0;
  logic [14:0] mie = '0, mip_wdata = '0;
  logic [31:0] mtvec = '0;
  logic        req;
  logic [4:0]  cause;
  logic [31:0] trap;
  logic [14:0] mip;

  int total = 0, bad = 0;

  // reference model state (valid after the most recent posedge)
  logic [14:0] m_pend;
  bit          m_req, m_clr;     // offering a request / clearing the taken cause
  int          m_cause, m_hold;
  logic [31:0] m_trap;
  int          prio [6] = '{14, 11, 3, 7, 12, 13};

  csr_int_scheduler #(.HOLDOFF_CYC(2), .CW(4)) dut (
    .s_clk_i(clk), .s_resetn_i(rst_n), .s_stall_i(stall), .s_flush_i(flush),
    .s_meip_i(meip), .s_mtip_i(mtip), .s_msip_i(msip), .s_uce_i(uce),
    .s_lcer_i(lcer), .s_fcer_i(fcer), .s_mie_i(mie), .s_gie_i(gie),
    .s_mtvec_i(mtvec), .s_mip_we_i(mip_we), .s_mip_wdata_i(mip_wdata),
    .s_int_ack_i(ack), .s_mret_i(mret), .s_int_req_o(req),
    .s_int_cause_o(cause), .s_int_trap_o(trap), .s_mip_o(mip));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_req = 0; m_clr = 0; m_cause = 0; m_trap = '0; m_hold = 0;
  endtask

  function automatic logic [31:0] trap_of(input logic [31:0] tv, input int c);
    logic [31:0] base;
    base = {tv[31:2], 2'b00};
`ifdef CSR_INT_VECTORED_EN
    if (tv[1:0] == 2'b01) return base + 32'(4 * c);
`endif
    return base;
  endfunction

  // advance the model by one clock edge using the currently driven inputs
  task automatic model_step();
    logic [14:0] elig, np;
    bit          can;
    int          pick;
    elig = m_pend & mie;
    can  = (elig != 0) && gie && (m_hold == 0);
    pick = 0;
    for (int i = 5; i >= 0; i--) if (elig[prio[i]]) pick = prio[i];
    np = '0;
    np[3] = msip; np[7] = mtip; np[11] = meip;
    for (int b = 12; b <= 14; b++) begin
      bit v;
      v = m_pend[b];
      if (mip_we && !mip_wdata[b]) v = 0;
      if (m_clr && m_cause == b)   v = 0;
      if ((b == 12 && lcer) || (b == 13 && fcer) || (b == 14 && uce)) v = 1;
      np[b] = v;
    end
    if (m_clr) m_clr = 0;
    else if (m_req) begin
      if (ack) begin m_req = 0; m_clr = 1; end
      else if (!elig[m_cause] || !gie || mret) m_req = 0;
    end else if (can && !stall) begin
      m_req = 1; m_cause = pick; m_trap = trap_of(mtvec, pick);
    end
    if (mret) m_hold = 2;
    else if (m_hold > 0 && !stall) m_hold--;
    m_pend = np;
  endtask

  // one cycle: model edge, DUT edge, then compare at the falling edge
  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("req",   32'(req),   32'(m_req));
    chk("mip",   32'(mip),   32'(m_pend));
    chk("cause", 32'(cause), 32'(m_cause));
    chk("trap",  trap,       m_trap);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_cause", 32'(cause), 32'd0);
    chk("rst_trap", trap, 32'd0);
    chk("rst_mip", 32'(mip), 32'd0);
    rst_n = 1;

    // ext + timer together: cause 11 first, then 7
    mie = 15'h0888; gie = 1; mtvec = 32'h0000_1000;
    meip = 1; mtip = 1;
    step();
    chk("lvl_mip", 32'(mip), 32'h0880);
    chk("lvl_noreq", 32'(req), 32'd0);
    step();
    chk("p11_req", 32'(req), 32'd1);
    chk("p11_cause", 32'(cause), 32'd11);
    chk("p11_trap", trap, 32'h0000_1000);
    ack = 1; meip = 0; mtvec = 32'h0000_1001;
    step();                     // -> CLR
    ack = 0;
    step();                     // -> IDLE
    step();                     // -> REQ cause 7
    chk("p7_req", 32'(req), 32'd1);
    chk("p7_cause", 32'(cause), 32'd7);
`ifdef CSR_INT_VECTORED_EN
    chk("p7_trap", trap, 32'h0000_101C);
`else
    chk("p7_trap", trap, 32'h0000_1000);
`endif
    ack = 1; mtip = 0; step(); ack = 0; step();
    chk("p7_done", 32'(req), 32'd0);

    // uce sticky, re-set during CLR
    mie = 15'h4000; uce = 1; step(); uce = 0;
    chk("uce_mip", 32'(mip[14]), 32'd1);
    step();
    chk("uce_cause", 32'(cause), 32'd14);
    ack = 1; step(); ack = 0;   // in CLR now
    uce = 1; step(); uce = 0;   // clear and set same edge: set wins
    chk("uce_setwins", 32'(mip[14]), 32'd1);
    step();                     // REQ again
    ack = 1; step(); ack = 0; step();
    chk("uce_cleared", 32'(mip[14]), 32'd0);

    // withdrawal when meip drops
    mie = 15'h0800; meip = 1; step(); step();
    chk("wd_req", 32'(req), 32'd1);
    meip = 0; step(); step();
    chk("wd_gone", 32'(req), 32'd0);
    chk("wd_mip", 32'(mip[11]), 32'd0);

    // hold-off after mret with stall
    mie = 15'h0008; msip = 1; mret = 1; stall = 1; step(); mret = 0;
    step(); step();
    chk("ho_stall", 32'(req), 32'd0);
    stall = 0; step(); step();
    chk("ho_window", 32'(req), 32'd0);
    step();
    chk("ho_req", 32'(req), 32'd1);
    chk("ho_cause", 32'(cause), 32'd3);
    ack = 1; msip = 0; step(); ack = 0; step();

    // MIP write 0 with simultaneous fcer pulse
    mie = '0; lcer = 1; fcer = 1; step(); lcer = 0; fcer = 0;
    chk("wr_pre", 32'(mip[13:12]), 32'd3);
    mip_we = 1; mip_wdata = '0; fcer = 1; step(); mip_we = 0; fcer = 0;
    chk("wr_post", 32'(mip[13:12]), 32'd2);

    // randomized phase
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        rst_n = 0; #1;
        chk("async_req", 32'(req), 32'd0);
        chk("async_mip", 32'(mip), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
      end
      stall = ($urandom % 4 == 0);
      flush = ($urandom % 8 == 0);
      if ($urandom % 10 == 0) meip = ~meip;
      if ($urandom % 10 == 0) mtip = ~mtip;
      if ($urandom % 10 == 0) msip = ~msip;
      uce  = ($urandom % 20 == 0);
      lcer = ($urandom % 20 == 0);
      fcer = ($urandom % 20 == 0);
      if (n % 50 == 0) mie = 15'($urandom);
      gie = ($urandom % 10 != 0);
      if ($urandom % 30 == 0) mtvec = $urandom;
      mip_we = ($urandom % 16 == 0);
      mip_wdata = 15'($urandom);
      ack  = m_req ? ($urandom % 2 == 0) : ($urandom % 16 == 0);
      mret = ($urandom % 25 == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
